// File: rtl/ap_mon_pkg.sv
// Shared types and constants for the ap_ctrl handshake performance monitor.
// ts_t/cnt_t are the widest supported timestamp/counter types; the RTL uses
// its TS_W/CNT_W parameters (<= 64) and slices LAT_INIT_MIN down to width.
package ap_mon_pkg;

  localparam int TS_W_MAX  = 64;
  localparam int CNT_W_MAX = 64;

  typedef logic [TS_W_MAX-1:0]  ts_t;
  typedef logic [CNT_W_MAX-1:0] cnt_t;

  // Bit positions inside rd_flags
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_BUSY = 0;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_state_e;

  // min_lat starts at all-ones so the first completion always replaces it
  localparam ts_t LAT_INIT_MIN = '1;

endpackage

// File: rtl/ap_ts_fifo.sv
// Purpose: DEPTH x W circular buffer of start timestamps for one channel.
// Latency: dout shows the oldest entry combinationally; push/pop take effect at the clock edge.
// Backpressure: none; a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
// Ports: clock/reset; push+din write, pop retires dout; full/empty/count status.
module ap_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (do_pop & ~do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define valid contents
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Purpose: per-channel ap_ctrl_hs/chain monitor: transaction counts and start-to-done latency (last/min/max).
// Latency: statistics update on the accepting edge; rd_* outputs are registered one cycle after rd_sel.
// Backpressure: passive observer, never stalls the handshake; overflowing starts are counted but not timed.
// Ports: clock, reset (async active-high), finish (freeze), ap_start/ap_ready/ap_done/ap_continue per channel,
//        rd_sel -> rd_start_cnt, rd_done_cnt, rd_last_lat, rd_min_lat, rd_max_lat, rd_inflight, rd_flags, frozen.
// Build option: define AP_MON_STALL_EN to add a per-channel stall counter and the rd_stall_cnt port.
module ap_ctrl_perf_monitor
  import ap_mon_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int DEPTH  = 4,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 32,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IF_W  = $clog2(DEPTH+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_start_cnt,
  output logic [CNT_W-1:0]  rd_done_cnt,
  output logic [TS_W-1:0]   rd_last_lat,
  output logic [TS_W-1:0]   rd_min_lat,
  output logic [TS_W-1:0]   rd_max_lat,
  output logic [IF_W-1:0]   rd_inflight,
  output logic [2:0]        rd_flags,
`ifdef AP_MON_STALL_EN
  output logic [CNT_W-1:0]  rd_stall_cnt,
`endif
  output logic              frozen
);

  localparam logic [TS_W-1:0] MIN_INIT = LAT_INIT_MIN[TS_W-1:0];

  logic [TS_W-1:0] ts;

  logic [CNT_W-1:0] start_cnt_a [NUM_CH];
  logic [CNT_W-1:0] done_cnt_a  [NUM_CH];
  logic [TS_W-1:0]  last_a      [NUM_CH];
  logic [TS_W-1:0]  min_a       [NUM_CH];
  logic [TS_W-1:0]  max_a       [NUM_CH];
  logic [IF_W-1:0]  infl_a      [NUM_CH];
  logic [2:0]       flags_a     [NUM_CH];
`ifdef AP_MON_STALL_EN
  logic [CNT_W-1:0] stall_a     [NUM_CH];
`endif

  // Freeze takes effect from the edge after finish is first seen, so the
  // cycle that raises finish still has its handshakes counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frozen <= 1'b0;
      ts     <= '0;
    end else begin
      if (finish)  frozen <= 1'b1;
      if (!frozen) ts     <= ts + TS_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             st_acc, dn_acc;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TS_W-1:0]  fifo_dout, lat;
    logic [IF_W-1:0]  fifo_count;
    logic             lat_vld;
    logic [CNT_W-1:0] start_cnt, done_cnt;
    logic [TS_W-1:0]  last_lat, min_lat, max_lat;
    logic             ovf, unf;
    logic [2:0]       flags;
    ch_state_e        state, state_nxt;

    assign st_acc = ap_start[c] & ap_ready[c] & ~frozen;
    assign dn_acc = ap_done[c] & ap_continue[c] & ~frozen;

    // Done on an empty FIFO with a same-cycle start pairs with that start
    // directly (latency 0) and leaves the FIFO untouched.
    assign fifo_pop  = dn_acc & ~fifo_empty;
    assign fifo_push = st_acc & ~(dn_acc & fifo_empty);
    assign lat_vld   = dn_acc & (~fifo_empty | st_acc);
    // Modular subtraction gives the right answer across one counter wrap
    assign lat       = fifo_empty ? '0 : (ts - fifo_dout);

    ap_ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (ts),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= CH_IDLE;
      else       state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        CH_IDLE: if (fifo_push) state_nxt = CH_BUSY;
        CH_BUSY: if (fifo_pop && !fifo_push && fifo_count == IF_W'(1)) state_nxt = CH_IDLE;
        default: state_nxt = CH_IDLE;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        start_cnt <= '0;
        done_cnt  <= '0;
        last_lat  <= '0;
        min_lat   <= MIN_INIT;
        max_lat   <= '0;
        ovf       <= 1'b0;
        unf       <= 1'b0;
      end else begin
        if (st_acc) start_cnt <= start_cnt + CNT_W'(1);
        if (dn_acc) done_cnt  <= done_cnt + CNT_W'(1);
        if (lat_vld) begin
          last_lat <= lat;
          if (lat < min_lat) min_lat <= lat;
          if (lat > max_lat) max_lat <= lat;
        end
        // Timestamp is lost only when no pop frees a slot this cycle
        if (fifo_push & fifo_full & ~fifo_pop) ovf <= 1'b1;
        if (dn_acc & fifo_empty & ~st_acc)     unf <= 1'b1;
      end
    end

    always_comb begin
      flags            = '0;
      flags[FLAG_OVF]  = ovf;
      flags[FLAG_UNF]  = unf;
      flags[FLAG_BUSY] = (state == CH_BUSY);
    end

    assign start_cnt_a[c] = start_cnt;
    assign done_cnt_a[c]  = done_cnt;
    assign last_a[c]      = last_lat;
    assign min_a[c]       = min_lat;
    assign max_a[c]       = max_lat;
    assign infl_a[c]      = fifo_count;
    assign flags_a[c]     = flags;

`ifdef AP_MON_STALL_EN
    logic [CNT_W-1:0] stall_cnt;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) stall_cnt <= '0;
      else if (ap_done[c] & ~ap_continue[c] & ~frozen) stall_cnt <= stall_cnt + CNT_W'(1);
    end
    assign stall_a[c] = stall_cnt;
`endif
  end

  // Registered readout; an out-of-range rd_sel matches no channel and reads zeros
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_start_cnt <= '0;
      rd_done_cnt  <= '0;
      rd_last_lat  <= '0;
      rd_min_lat   <= MIN_INIT;
      rd_max_lat   <= '0;
      rd_inflight  <= '0;
      rd_flags     <= '0;
`ifdef AP_MON_STALL_EN
      rd_stall_cnt <= '0;
`endif
    end else begin
      rd_start_cnt <= '0;
      rd_done_cnt  <= '0;
      rd_last_lat  <= '0;
      rd_min_lat   <= '0;
      rd_max_lat   <= '0;
      rd_inflight  <= '0;
      rd_flags     <= '0;
`ifdef AP_MON_STALL_EN
      rd_stall_cnt <= '0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_sel == SEL_W'(c)) begin
          rd_start_cnt <= start_cnt_a[c];
          rd_done_cnt  <= done_cnt_a[c];
          rd_last_lat  <= last_a[c];
          rd_min_lat   <= min_a[c];
          rd_max_lat   <= max_a[c];
          rd_inflight  <= infl_a[c];
          rd_flags     <= flags_a[c];
`ifdef AP_MON_STALL_EN
          rd_stall_cnt <= stall_a[c];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
module tb_ap_ctrl_perf_monitor;

  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int CNT_W  = 16;
  localparam int SEL_W  = 2;
  localparam int IF_W   = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              finish;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_start_cnt, rd_done_cnt;
  logic [TS_W-1:0]   rd_last_lat, rd_min_lat, rd_max_lat;
  logic [IF_W-1:0]   rd_inflight;
  logic [2:0]        rd_flags;
  logic              frozen;
`ifdef AP_MON_STALL_EN
  logic [CNT_W-1:0]  rd_stall_cnt;
`endif

  ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .finish       (finish),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .rd_sel       (rd_sel),
    .rd_start_cnt (rd_start_cnt),
    .rd_done_cnt  (rd_done_cnt),
    .rd_last_lat  (rd_last_lat),
    .rd_min_lat   (rd_min_lat),
    .rd_max_lat   (rd_max_lat),
    .rd_inflight  (rd_inflight),
    .rd_flags     (rd_flags),
`ifdef AP_MON_STALL_EN
    .rd_stall_cnt (rd_stall_cnt),
`endif
    .frozen       (frozen)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of start times per channel plus plain counters
  int m_ts;
  bit m_frozen;
  int q       [NUM_CH][$];
  int m_start [NUM_CH];
  int m_done  [NUM_CH];
  int m_last  [NUM_CH];
  int m_min   [NUM_CH];
  int m_max   [NUM_CH];
  int m_stall [NUM_CH];
  bit m_ovf   [NUM_CH];
  bit m_unf   [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ts = 0;
    m_frozen = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      m_start[c] = 0; m_done[c] = 0; m_last[c] = 0;
      m_min[c] = 255; m_max[c] = 0; m_stall[c] = 0;
      m_ovf[c] = 0; m_unf[c] = 0;
    end
  endtask

  task automatic record(input int c, input int lat);
    m_last[c] = lat;
    if (lat < m_min[c]) m_min[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
  endtask

  // Applies the current inputs as one clock edge to the model
  task automatic model_edge();
    if (!m_frozen) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit st, dn, paired;
        st = ap_start[c] & ap_ready[c];
        dn = ap_done[c] & ap_continue[c];
        paired = 0;
        if (ap_done[c] && !ap_continue[c]) m_stall[c]++;
        if (st) m_start[c]++;
        if (dn) begin
          m_done[c]++;
          if (q[c].size() > 0) record(c, (m_ts - q[c].pop_front()) & 255);
          else if (st) begin record(c, 0); paired = 1; end
          else m_unf[c] = 1;
        end
        if (st && !paired) begin
          if (q[c].size() < DEPTH) q[c].push_back(m_ts);
          else m_ovf[c] = 1;
        end
      end
      m_ts = (m_ts + 1) % 256;
    end
    if (finish) m_frozen = 1;
  endtask

  // One clock: expected readout comes from the pre-edge model state for rd_sel
  task automatic tick();
    int e_start, e_done, e_last, e_min, e_max, e_infl, e_flags, e_stall;
    e_start = 0; e_done = 0; e_last = 0; e_min = 0; e_max = 0; e_infl = 0; e_flags = 0; e_stall = 0;
    if (int'(rd_sel) < NUM_CH) begin
      int c;
      c = int'(rd_sel);
      e_start = m_start[c] % 65536;
      e_done  = m_done[c] % 65536;
      e_last  = m_last[c];
      e_min   = m_min[c];
      e_max   = m_max[c];
      e_infl  = q[c].size();
      e_flags = (m_ovf[c] ? 4 : 0) + (m_unf[c] ? 2 : 0) + ((q[c].size() > 0) ? 1 : 0);
      e_stall = m_stall[c] % 65536;
    end
    model_edge();
    @(posedge clock);
    #1;
    chk("start_cnt", 32'(rd_start_cnt), e_start);
    chk("done_cnt",  32'(rd_done_cnt),  e_done);
    chk("last_lat",  32'(rd_last_lat),  e_last);
    chk("min_lat",   32'(rd_min_lat),   e_min);
    chk("max_lat",   32'(rd_max_lat),   e_max);
    chk("inflight",  32'(rd_inflight),  e_infl);
    chk("flags",     32'(rd_flags),     e_flags);
    chk("frozen",    32'(frozen),       32'(m_frozen));
`ifdef AP_MON_STALL_EN
    chk("stall_cnt", 32'(rd_stall_cnt), e_stall);
`endif
  endtask

  task automatic clr();
    ap_start = '0;
    ap_ready = '1;
    ap_done = '0;
    ap_continue = '1;
    finish = 1'b0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    logic [8:0] st_pat, dn_pat;
    clr();
    rd_sel = '0;
    reset = 1'b1;
    model_reset();

    // Reset state and single transaction, start at ts 10, done at ts 17
    do_reset();
    chk("rst_start", 32'(rd_start_cnt), 0);
    chk("rst_min",   32'(rd_min_lat), 255);
    chk("rst_max",   32'(rd_max_lat), 0);
    chk("rst_flags", 32'(rd_flags), 0);
    chk("rst_frozen", 32'(frozen), 0);
    idle(10);
    ap_start[0] = 1'b1; tick();
    idle(1);
    chk("t1_busy", 32'(rd_flags), 1);
    idle(5);
    ap_done[0] = 1'b1; tick();
    idle(1);
    chk("t1_last", 32'(rd_last_lat), 7);
    chk("t1_min",  32'(rd_min_lat), 7);
    chk("t1_max",  32'(rd_max_lat), 7);
    chk("t1_cnts", 32'({rd_start_cnt, rd_done_cnt}), 32'h0001_0001);
    chk("t1_idle", 32'(rd_flags), 0);

    // Pipelined: starts at 0,1,2 and dones at 5,7,8
    do_reset();
    st_pat = 9'b000000111;
    dn_pat = 9'b110100000;
    for (int i = 0; i < 9; i++) begin
      ap_start[0] = st_pat[i];
      ap_done[0]  = dn_pat[i];
      tick();
      if (i == 3) chk("t2_peak", 32'(rd_inflight), 3);
    end
    idle(1);
    chk("t2_last", 32'(rd_last_lat), 6);
    chk("t2_min",  32'(rd_min_lat), 5);
    chk("t2_max",  32'(rd_max_lat), 6);

    // Overflow: five starts into a four-deep FIFO, then four dones
    do_reset();
    ap_start[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle(1);
    chk("t3_infl", 32'(rd_inflight), 4);
    chk("t3_start", 32'(rd_start_cnt), 5);
    chk("t3_flags", 32'(rd_flags), 5);
    ap_done[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle(1);
    chk("t3_done", 32'(rd_done_cnt), 4);
    chk("t3_infl0", 32'(rd_inflight), 0);
    chk("t3_ovf", 32'(rd_flags), 4);

    // Underflow, then same-cycle start+done on an empty FIFO
    do_reset();
    ap_done[0] = 1'b1; tick();
    idle(1);
    chk("t4_unf", 32'(rd_flags), 2);
    chk("t4_done", 32'(rd_done_cnt), 1);
    chk("t4_min", 32'(rd_min_lat), 255);
    do_reset();
    ap_start[0] = 1'b1; ap_done[0] = 1'b1; tick();
    idle(1);
    chk("t4_zlat", 32'(rd_last_lat), 0);
    chk("t4_zmin", 32'(rd_min_lat), 0);
    chk("t4_zflags", 32'(rd_flags), 0);

    // Timestamp wrap: start at ts 250, done 10 cycles later; then freeze
    do_reset();
    rd_sel = 2'd1;
    idle(250);
    ap_start[1] = 1'b1; tick();
    idle(9);
    ap_done[1] = 1'b1; tick();
    idle(1);
    chk("t5_wrap", 32'(rd_last_lat), 10);
    finish = 1'b1; tick();
    clr();
    ap_start = '1; ap_done = '1;
    for (int i = 0; i < 4; i++) tick();
    idle(1);
    chk("t5_frozen", 32'(frozen), 1);
    chk("t5_start", 32'(rd_start_cnt), 1);
    chk("t5_done", 32'(rd_done_cnt), 1);

    // Asynchronous reset in the middle of a transaction
    do_reset();
    rd_sel = 2'd2;
    ap_start[2] = 1'b1; tick();
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_start", 32'(rd_start_cnt), 0);
    chk("t6_min", 32'(rd_min_lat), 255);
    chk("t6_flags", 32'(rd_flags), 0);
    chk("t6_infl", 32'(rd_inflight), 0);
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    idle(2);
    chk("t6_post", 32'(rd_flags), 0);

`ifdef AP_MON_STALL_EN
    do_reset();
    rd_sel = 2'd0;
    ap_done[0] = 1'b1; ap_continue[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    idle(1);
    chk("t7_stall", 32'(rd_stall_cnt), 3);
`endif

    // Randomized traffic on all channels, including out-of-range rd_sel
    do_reset();
    for (int i = 0; i < 700; i++) begin
      ap_start    = NUM_CH'($urandom);
      ap_ready    = NUM_CH'($urandom) | NUM_CH'($urandom);
      ap_done     = NUM_CH'($urandom) & NUM_CH'($urandom);
      ap_continue = NUM_CH'($urandom) | NUM_CH'($urandom);
      rd_sel      = SEL_W'($urandom_range(0, 3));
      finish      = (i == 650);
      tick();
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
Synthesizable, parametrised successor to the testbench-only single-module status monitor.
- Watches NUM_CH independent ap_ctrl_hs/chain handshakes (ap_start/ap_ready/ap_done/ap_continue).
- Per channel, counts accepted transactions and keeps a FIFO of start timestamps, so pipelined (overlapping) transactions are measured.
- Reports last, min and max start-to-done latency per channel through a registered readout port.
- Sits beside the HLS top (e.g. sigmoid_top) in both simulation and on-chip debug builds.

Parameters:
NUM_CH, 1, number of monitored handshake channels (1..16)
DEPTH, 4, max outstanding starts per channel (power of 2, >=2)
TS_W, 32, timestamp/latency width
CNT_W, 32, transaction counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
finish  in  1  end-of-run; freezes all statistics
ap_start  in  NUM_CH  per-channel start
ap_ready  in  NUM_CH  per-channel ready
ap_done  in  NUM_CH  per-channel done
ap_continue  in  NUM_CH  per-channel continue (tie 1 for ap_ctrl_hs)
rd_sel  in  max(1,$clog2(NUM_CH))  channel to read
rd_start_cnt  out  CNT_W  accepted starts
rd_done_cnt  out  CNT_W  accepted dones
rd_last_lat  out  TS_W  latency of most recent completion
rd_min_lat  out  TS_W  minimum latency
rd_max_lat  out  TS_W  maximum latency
rd_inflight  out  $clog2(DEPTH+1)  outstanding transactions
rd_flags  out  3  {overflow, underflow, busy}
frozen  out  1  statistics frozen

Behaviour:
- Reset (async assert, sync release):
  - All counters, FIFOs and flags clear; cycle counter = 0.
  - min_lat = all-ones; max_lat and last_lat = 0.
  - frozen = 0; all rd_* outputs = 0, except rd_min_lat = all-ones.
- Reset mid-run discards outstanding timestamps with no flag set.
- Cycle counter: free-running TS_W bits, wraps modulo 2^TS_W. Latency = (done_ts - start_ts) mod 2^TS_W, correct across one wrap.
- Start accept (per channel) = ap_start & ap_ready & !frozen. Push the current timestamp and increment start_cnt (wrapping).
- Done accept = ap_done & ap_continue & !frozen. Pop the oldest timestamp, compute lat, and in the same edge update:
  - last_lat = lat
  - min_lat = min(min_lat, lat)
  - max_lat = max(max_lat, lat)
  - done_cnt += 1
- Same-cycle start and done (zero-latency channel or pipelined overlap):
  - Pop uses the pre-push contents; if the FIFO is empty, the done pairs with this cycle's start and lat = 0.
  - inflight is unchanged.
- FIFO full and a start is accepted: start_cnt still increments, timestamp is dropped, overflow flag set (sticky until reset).
- FIFO empty and a done is accepted (no same-cycle start): done_cnt increments, latency stats unchanged, underflow flag set (sticky).
- Per-channel FSM:
  - IDLE -> BUSY on push.
  - BUSY -> IDLE when a pop leaves inflight = 0 with no simultaneous push.
  - busy flag = state==BUSY.
- finish: sampled each edge. The first cycle it is 1 sets frozen (sticky until reset). From the next edge no statistic changes; the cycle counter also stops.
- Readout: all rd_* outputs are registered, one-cycle latency from rd_sel. rd_sel >= NUM_CH returns all zeros.

Optional Feature:
AP_MON_STALL_EN:
- Defined: adds per-channel stall counter (CNT_W) incrementing each unfrozen cycle with ap_done & !ap_continue, plus output port rd_stall_cnt (CNT_W), registered like the other rd_* outputs.
- Undefined: no counter and no port.

Decomposition:
- Package ap_mon_pkg: ts_t, cnt_t, flag index localparams (FLAG_OVF=2, FLAG_UNF=1, FLAG_BUSY=0), channel state enum {CH_IDLE, CH_BUSY}, LAT_INIT_MIN constant.
- Sub-module ap_ts_fifo: one instance per channel, generate loop. DEPTH x TS_W circular buffer with push/pop/full/empty/count and same-cycle push+pop support.

Test Plan:
- Single channel, start at cycle 10, done at cycle 17 -> last=min=max=7, start_cnt=done_cnt=1, busy 1 then 0.
- Pipelined: starts at 0,1,2, dones at 5,7,8 -> lats 5,6,6; min=5, max=6, inflight peaks at 3.
- DEPTH=4: 5 starts without done -> inflight=4, overflow=1, start_cnt=5. Then 4 dones -> done_cnt=4, inflight=0.
- Done with empty FIFO -> underflow=1, done_cnt=1, min stays all-ones. Same-cycle start+done on empty -> lat=0, no underflow.
- Counter wrap (TS_W=8): start at ts 250, done 10 cycles later -> lat=10. Assert finish, then more handshakes -> counts unchanged, frozen=1.
- Async reset pulsed mid-transaction -> all outputs at reset values immediately. With AP_MON_STALL_EN, 3 cycles of ap_done & !ap_continue -> rd_stall_cnt=3.
